ebus_mux_n: RTL and testbench

Parametrised, registered EBUS data multiplexer with arbitration and fault monitoring for the KL10PV top level. It merges `NDRV` per-board EBUS driver records into a single `WIDTH`-bit EBUS data value using fixed priority, with index 0 highest (front end). It also detects multi-driver contention, records the first offending driver set, counts contention events and flags a driver that holds the bus past a watchdog limit. The block's output feeds the `ebus_dNN_e_h` fan-out.

---
 rtl/ebus_mux_n.sv | 139 +++++++++++++
 tb/tb_ebus_mux_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_mux_n.sv
// Registered fixed-priority EBUS data multiplexer with contention capture
// and an ownership watchdog; driver 0 has the highest priority.
module ebus_mux_n #(
  parameter int NDRV  = 32,
  parameter int WIDTH = 36,
  parameter int TMO   = 1023,
  parameter int CNTW  = 8
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic [NDRV-1:0]           drv_driving,
  input  logic [NDRV*WIDTH-1:0]     drv_data,
  input  logic                      clr_err_h,
  output logic [WIDTH-1:0]          ebus_data,
  output logic                      ebus_valid_h,
  output logic [$clog2(NDRV)-1:0]   ebus_owner,
  output logic                      conflict_h,
  output logic [NDRV-1:0]           conflict_mask,
  output logic [CNTW-1:0]           conflict_cnt,
  output logic                      stuck_h,
  output logic [$clog2(NDRV)-1:0]   stuck_owner
);

  localparam int OW = $clog2(NDRV);
  localparam int RW = $clog2(TMO + 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             conflict_q, conflict_d;
  logic [NDRV-1:0]  mask_q, mask_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             stuck_q, stuck_d;
  logic [OW-1:0]    stuck_owner_q, stuck_owner_d;
  logic [RW-1:0]    run_q, run_d;

  logic [OW-1:0]    sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             any_drv;
  logic             multi_drv;
  logic             stuck_evt;

  // Scanning downwards leaves the lowest asserted index as the winner.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (drv_driving[i]) begin
        sel_idx  = OW'(i);
        sel_data = drv_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign any_drv   = |drv_driving;
  assign multi_drv = |(drv_driving & (drv_driving - NDRV'(1)));

  always_comb begin
    data_d    = any_drv ? sel_data : '0;
    valid_d   = any_drv;
    owner_d   = any_drv ? sel_idx : owner_q;
    run_d     = '0;
    stuck_evt = 1'b0;
    if (any_drv) begin
      if (valid_q && (sel_idx == owner_q)) begin
        if (run_q == RW'(TMO)) begin
          run_d     = run_q;
          stuck_evt = 1'b1;
        end else begin
          run_d = run_q + 1'b1;
        end
      end else begin
        run_d = RW'(1);
      end
    end
  end

  // A clear in the same cycle as a fault discards that cycle's fault.
  always_comb begin
    conflict_d    = conflict_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    stuck_d       = stuck_q;
    stuck_owner_d = stuck_owner_q;
    if (clr_err_h) begin
      conflict_d    = 1'b0;
      mask_d        = '0;
      cnt_d         = '0;
      stuck_d       = 1'b0;
      stuck_owner_d = '0;
    end else begin
      if (multi_drv) begin
        if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (!conflict_q) begin
          conflict_d = 1'b1;
          mask_d     = drv_driving;
        end
      end
      if (stuck_evt && !stuck_q) begin
        stuck_d       = 1'b1;
        stuck_owner_d = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      data_q        <= '0;
      valid_q       <= 1'b0;
      owner_q       <= '0;
      conflict_q    <= 1'b0;
      mask_q        <= '0;
      cnt_q         <= '0;
      stuck_q       <= 1'b0;
      stuck_owner_q <= '0;
      run_q         <= '0;
    end else begin
      data_q        <= data_d;
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      conflict_q    <= conflict_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      stuck_q       <= stuck_d;
      stuck_owner_q <= stuck_owner_d;
      run_q         <= run_d;
    end
  end

  assign ebus_data     = data_q;
  assign ebus_valid_h  = valid_q;
  assign ebus_owner    = owner_q;
  assign conflict_h    = conflict_q;
  assign conflict_mask = mask_q;
  assign conflict_cnt  = cnt_q;
  assign stuck_h       = stuck_q;
  assign stuck_owner   = stuck_owner_q;

endmodule

// File: tb/tb_ebus_mux_n.sv
// Scoreboard bench for ebus_mux_n: stimulus pushes model predictions into a
// queue, a monitor pops one per cycle and compares against the DUT.
module tb_ebus_mux_n;

  localparam int NDRV  = 8;
  localparam int WIDTH = 36;
  localparam int TMO   = 8;
  localparam int CNTW  = 2;
  localparam int OW    = $clog2(NDRV);

  logic                  clk;
  logic                  reset_l;
  logic [NDRV-1:0]       drv_driving;
  logic [NDRV*WIDTH-1:0] drv_data;
  logic                  clr_err_h;
  logic [WIDTH-1:0]      ebus_data;
  logic                  ebus_valid_h;
  logic [OW-1:0]         ebus_owner;
  logic                  conflict_h;
  logic [NDRV-1:0]       conflict_mask;
  logic [CNTW-1:0]       conflict_cnt;
  logic                  stuck_h;
  logic [OW-1:0]         stuck_owner;

  ebus_mux_n #(.NDRV(NDRV), .WIDTH(WIDTH), .TMO(TMO), .CNTW(CNTW)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .drv_driving  (drv_driving),
    .drv_data     (drv_data),
    .clr_err_h    (clr_err_h),
    .ebus_data    (ebus_data),
    .ebus_valid_h (ebus_valid_h),
    .ebus_owner   (ebus_owner),
    .conflict_h   (conflict_h),
    .conflict_mask(conflict_mask),
    .conflict_cnt (conflict_cnt),
    .stuck_h      (stuck_h),
    .stuck_owner  (stuck_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             valid;
    logic [OW-1:0]    owner;
    logic             conflict;
    logic [NDRV-1:0]  mask;
    logic [CNTW-1:0]  cnt;
    logic             stuck;
    logic [OW-1:0]    stuckOwner;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] words[NDRV];
  logic [WIDTH-1:0] mData;
  logic             mValid, mConflict, mStuck;
  int               mOwner, mStuckOwner, mCnt, mHeld;
  logic [NDRV-1:0]  mMask;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    mData = '0; mValid = 1'b0; mOwner = 0; mConflict = 1'b0; mMask = '0;
    mCnt = 0; mStuck = 1'b0; mStuckOwner = 0; mHeld = 0;
  endtask

  // Drives one cycle of inputs and predicts the outputs after the next edge.
  task automatic driveNow(input logic [NDRV-1:0] drv, input logic clr);
    int winner;
    logic stuckEvt;
    exp_t e;
    drv_driving = drv;
    clr_err_h   = clr;
    for (int i = 0; i < NDRV; i++) drv_data[i*WIDTH +: WIDTH] = words[i];
    winner = -1;
    for (int i = 0; i < NDRV; i++) if (drv[i] && winner < 0) winner = i;
    stuckEvt = 1'b0;
    if (winner >= 0) begin
      if (mValid && winner == mOwner) mHeld++;
      else mHeld = 1;
      stuckEvt = (mHeld > TMO);
      mData = words[winner]; mValid = 1'b1; mOwner = winner;
    end else begin
      mHeld = 0; mData = '0; mValid = 1'b0;
    end
    if (clr) begin
      mConflict = 1'b0; mMask = '0; mCnt = 0; mStuck = 1'b0; mStuckOwner = 0;
    end else begin
      if ($countones(drv) >= 2) begin
        if (mCnt < (1 << CNTW) - 1) mCnt++;
        if (!mConflict) begin
          mConflict = 1'b1;
          mMask = drv;
        end
      end
      if (stuckEvt && !mStuck) begin
        mStuck = 1'b1;
        mStuckOwner = winner;
      end
    end
    e.data = mData; e.valid = mValid; e.owner = OW'(mOwner);
    e.conflict = mConflict; e.mask = mMask; e.cnt = CNTW'(mCnt);
    e.stuck = mStuck; e.stuckOwner = OW'(mStuckOwner);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [NDRV-1:0] drv, input logic clr);
    @(negedge clk);
    driveNow(drv, clr);
  endtask

  task automatic hold(input logic [NDRV-1:0] drv, input int n);
    for (int k = 0; k < n; k++) applyStimulus(drv, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " data"}, 64'(ebus_data), 64'd0);
    checkOutput({tag, " valid"}, 64'(ebus_valid_h), 64'd0);
    checkOutput({tag, " owner"}, 64'(ebus_owner), 64'd0);
    checkOutput({tag, " conflict"}, 64'(conflict_h), 64'd0);
    checkOutput({tag, " mask"}, 64'(conflict_mask), 64'd0);
    checkOutput({tag, " cnt"}, 64'(conflict_cnt), 64'd0);
    checkOutput({tag, " stuck"}, 64'(stuck_h), 64'd0);
    checkOutput({tag, " stuckOwner"}, 64'(stuck_owner), 64'd0);
  endtask

  // Monitor: one prediction is retired per clock edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("ebus_data", 64'(ebus_data), 64'(e.data));
        checkOutput("ebus_valid_h", 64'(ebus_valid_h), 64'(e.valid));
        checkOutput("ebus_owner", 64'(ebus_owner), 64'(e.owner));
        checkOutput("conflict_h", 64'(conflict_h), 64'(e.conflict));
        checkOutput("conflict_mask", 64'(conflict_mask), 64'(e.mask));
        checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
        checkOutput("stuck_h", 64'(stuck_h), 64'(e.stuck));
        checkOutput("stuck_owner", 64'(stuck_owner), 64'(e.stuckOwner));
      end
    end
  end

  initial begin
    logic [NDRV-1:0] drv;
    int mode;
    int budget;
    reset_l = 1'b0;
    drv_driving = '0;
    drv_data = '0;
    clr_err_h = 1'b0;
    for (int i = 0; i < NDRV; i++) words[i] = WIDTH'(i * 36'o1111 + 36'o7);
    modelReset();
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset_l = 1'b1;

    words[5] = 36'o123456701234;
    hold(8'b0010_0000, 3);

    words[3] = 36'o111111111111;
    words[7] = 36'o777777777777;
    applyStimulus(8'b1000_1000, 1'b0);
    applyStimulus(8'b0000_0110, 1'b0);
    applyStimulus(8'b0000_0000, 1'b1);

    hold(8'b0000_0011, 6);
    applyStimulus(8'b0000_0011, 1'b1);
    applyStimulus(8'b0000_0011, 1'b0);
    applyStimulus(8'b0000_0000, 1'b0);
    applyStimulus(8'b0000_0000, 1'b1);

    hold(8'b0000_0001, 8);
    applyStimulus(8'b0000_0000, 1'b0);
    hold(8'b0000_0001, 9);
    applyStimulus(8'b0000_0001, 1'b1);
    applyStimulus(8'b0000_0001, 1'b0);
    applyStimulus(8'b0000_0000, 1'b1);
    hold(8'b0000_0001, 8);
    hold(8'b0001_0000, 3);
    applyStimulus(8'b0000_0000, 1'b0);

    hold(8'b0000_0100, 3);
    @(posedge clk);
    #3;
    reset_l = 1'b0;
    modelReset();
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    reset_l = 1'b1;
    driveNow(8'b0000_0100, 1'b0);
    hold(8'b0000_0100, 2);

    drv = '0;
    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 9);
      for (int i = 0; i < NDRV; i++)
        if ($urandom_range(0, 3) == 0) words[i] = {4'($urandom_range(0, 15)), 32'($urandom)};
      if (mode == 0) drv = '0;
      else if (mode == 8) drv = NDRV'(1) << $urandom_range(0, NDRV - 1);
      else if (mode == 9) drv = NDRV'($urandom);
      applyStimulus(drv, $urandom_range(0, 15) == 0);
    end
    applyStimulus('0, 1'b0);

    budget = 20;
    while (expQ.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
